// File: rtl/pe_controller.sv
// -----------------------------------------------------------------------------
// pe_controller
//
// Matrix-vector multiply engine for a signed fixed-point VECTOR_SIZE x
// VECTOR_SIZE matrix M and VECTOR_SIZE-element vector x. All operands live in
// an external BRAM with a 2-cycle read latency:
//   words 0 .. VS*VS-1            : M, row-major
//   words VS*VS .. VS*VS+VS-1     : x
//   words VS*VS+VS .. VS*VS+2VS-1 : y = M*x (written back)
// A job first copies M and x into local buffers (LOAD), then for each row
// accumulates one MAC per cycle (CALC) and writes the truncated result (WRITE).
//
// Ports
//   aclk         system clock
//   aresetn      asynchronous active-low reset
//   start        one-cycle pulse, accepted in IDLE or DONE only
//   done         high while the finished job is waiting for the next start
//   BRAM_ADDR    byte address (word index * 4)
//   BRAM_WRDATA  result word during WRITE, zero otherwise
//   BRAM_WE      4'hF during WRITE, 4'h0 otherwise
//   BRAM_CLK     aclk forwarded to the BRAM
//   BRAM_RDDATA  read data, valid two aclk edges after the address
// -----------------------------------------------------------------------------
module pe_controller #(
    parameter int DATA_WIDTH  = 32,
    parameter int VECTOR_SIZE = 64,
    parameter int L_RAM_SIZE  = 12,
    parameter int R_RAM_SIZE  = 6,
    parameter int FRAC_BITS   = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    output logic                  done,
    output logic [31:0]           BRAM_ADDR,
    output logic [DATA_WIDTH-1:0] BRAM_WRDATA,
    output logic [3:0]            BRAM_WE,
    output logic                  BRAM_CLK,
    input  logic [DATA_WIDTH-1:0] BRAM_RDDATA
);

    localparam int             ACC_W      = 2 * DATA_WIDTH;
    localparam int             ROW_W      = $clog2(VECTOR_SIZE);
    localparam int             COL_W      = ROW_W + 1;
    localparam logic [31:0]    MAT_WORDS  = 32'(VECTOR_SIZE * VECTOR_SIZE);
    localparam logic [31:0]    LOAD_WORDS = MAT_WORDS + 32'(VECTOR_SIZE);
    localparam logic [31:0]    RES_BASE   = LOAD_WORDS;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(VECTOR_SIZE - 1);
    localparam logic [COL_W-1:0] COL_END  = COL_W'(VECTOR_SIZE);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CALC,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;

    // LOAD: issue counter and a 2-deep tag pipeline matching the BRAM latency
    logic [31:0]             r_rd_addr;
    logic [1:0]              r_tag_vld;
    logic [31:0]             r_tag_addr0;
    logic [31:0]             r_tag_addr1;

    // CALC: row/column counters and one-stage operand fetch from local buffers
    logic [ROW_W-1:0]        r_row;
    logic [COL_W-1:0]        r_col;
    logic                    r_mac_vld;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [DATA_WIDTH-1:0] r_m_q;
    logic signed [DATA_WIDTH-1:0] r_x_q;

    logic [DATA_WIDTH-1:0]   r_l_ram [2**L_RAM_SIZE];
    logic [DATA_WIDTH-1:0]   r_r_ram [2**R_RAM_SIZE];

    logic                    w_issue;
    logic                    w_last_cap;
    logic                    w_row_done;
    logic [L_RAM_SIZE-1:0]   w_l_rd_idx;
    logic [R_RAM_SIZE-1:0]   w_r_rd_idx;
    logic [R_RAM_SIZE-1:0]   w_r_cap_idx;
    logic signed [ACC_W-1:0] w_prod;

    assign BRAM_CLK = aclk;
    assign done     = (r_state == ST_DONE);

    assign w_issue    = (r_state == ST_LOAD) && (r_rd_addr < LOAD_WORDS);
    assign w_last_cap = r_tag_vld[1] && (r_tag_addr1 == LOAD_WORDS - 32'd1);
    // The row is finished once every column was issued and the last product
    // has drained out of the fetch stage into the accumulator.
    assign w_row_done = (r_col == COL_END) && !r_mac_vld;

    assign w_l_rd_idx  = L_RAM_SIZE'(32'(r_row) * 32'(VECTOR_SIZE) + 32'(r_col));
    assign w_r_rd_idx  = R_RAM_SIZE'(r_col);
    assign w_r_cap_idx = R_RAM_SIZE'(r_tag_addr1 - MAT_WORDS);

    // Size casts keep signedness, so both operands are sign-extended first.
    assign w_prod = ACC_W'(r_m_q) * ACC_W'(r_x_q);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: next_state is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next_state = ST_LOAD;
            ST_LOAD:  if (w_last_cap) w_next_state = ST_CALC;
            ST_CALC:  if (w_row_done) w_next_state = ST_WRITE;
            ST_WRITE: w_next_state = (r_row == LAST_ROW) ? ST_DONE : ST_CALC;
            ST_DONE:  if (start) w_next_state = ST_LOAD;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rd_addr   <= '0;
            r_tag_vld   <= '0;
            r_tag_addr0 <= '0;
            r_tag_addr1 <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_mac_vld   <= 1'b0;
            r_acc       <= '0;
        end else begin
            r_tag_vld   <= {r_tag_vld[0], w_issue};
            r_tag_addr0 <= r_rd_addr;
            r_tag_addr1 <= r_tag_addr0;
            r_mac_vld   <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_rd_addr <= '0;
                        r_row     <= '0;
                        r_col     <= '0;
                        r_acc     <= '0;
                    end
                end
                ST_LOAD: begin
                    if (w_issue) r_rd_addr <= r_rd_addr + 32'd1;
                end
                ST_CALC: begin
                    if (r_col != COL_END) begin
                        r_col     <= r_col + COL_W'(1);
                        r_mac_vld <= 1'b1;
                    end
                    if (r_mac_vld) r_acc <= r_acc + w_prod;
                end
                ST_WRITE: begin
                    r_col <= '0;
                    r_acc <= '0;
                    r_row <= r_row + ROW_W'(1);
                end
                default: ;
            endcase
        end
    end

    // NOTE: the local buffers and their read registers have no reset; their
    // contents are only meaningful after a LOAD, and leaving them unreset lets
    // them map onto block RAM.
    always_ff @(posedge aclk) begin
        if (r_tag_vld[1]) begin
            if (r_tag_addr1 < MAT_WORDS) begin
                r_l_ram[r_tag_addr1[L_RAM_SIZE-1:0]] <= BRAM_RDDATA;
            end else begin
                r_r_ram[w_r_cap_idx] <= BRAM_RDDATA;
            end
        end
        r_m_q <= r_l_ram[w_l_rd_idx];
        r_x_q <= r_r_ram[w_r_rd_idx];
    end

    // BRAM drive is purely a function of state and counters, so it is zero
    // the instant reset forces the FSM back to IDLE.
    always_comb begin
        BRAM_ADDR   = '0;
        BRAM_WE     = 4'h0;
        BRAM_WRDATA = '0;
        if (w_issue) begin
            BRAM_ADDR = {r_rd_addr[29:0], 2'b00};
        end
        if (r_state == ST_WRITE) begin
            BRAM_ADDR   = (RES_BASE + 32'(r_row)) << 2;
            BRAM_WE     = 4'hF;
            BRAM_WRDATA = r_acc[FRAC_BITS+DATA_WIDTH-1:FRAC_BITS];
        end
    end

endmodule

// File: tb/tb_pe_controller.sv
// -----------------------------------------------------------------------------
// tb_pe_controller
//
// Drives pe_controller against a behavioural BRAM (2-cycle read latency). The
// matrix/vector region is generated from the active test-vector record; the
// result region is captured into y_mem so each job's output can be compared
// with hand-computed values from the table.
// -----------------------------------------------------------------------------
module tb_pe_controller;

    localparam int VS       = 64;
    localparam int DW       = 32;
    localparam int MAT_W    = VS * VS;
    localparam int RES_BASE = MAT_W + VS;
    localparam int BUDGET   = 12000;

    logic          aclk    = 1'b0;
    logic          aresetn = 1'b0;
    logic          start   = 1'b0;
    logic          done;
    logic [31:0]   BRAM_ADDR;
    logic [DW-1:0] BRAM_WRDATA;
    logic [3:0]    BRAM_WE;
    logic          BRAM_CLK;
    logic [DW-1:0] BRAM_RDDATA = '0;

    pe_controller #(
        .DATA_WIDTH (DW),
        .VECTOR_SIZE(VS),
        .L_RAM_SIZE (12),
        .R_RAM_SIZE (6),
        .FRAC_BITS  (16)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .start      (start),
        .done       (done),
        .BRAM_ADDR  (BRAM_ADDR),
        .BRAM_WRDATA(BRAM_WRDATA),
        .BRAM_WE    (BRAM_WE),
        .BRAM_CLK   (BRAM_CLK),
        .BRAM_RDDATA(BRAM_RDDATA)
    );

    always #5 aclk = ~aclk;

    // One job: M[i][i] = m_diag for i < diag_len (0 beyond), M[i][j] = m_off
    // for i != j; x[j] = x_base + j*x_step for j < x_len, else 0.
    // Expected: y[0] = y0, y[i] = y_base + i*y_step for i > 0.
    typedef struct {
        string       name;
        logic [31:0] m_diag;
        int          diag_len;
        logic [31:0] m_off;
        logic [31:0] x_base;
        logic [31:0] x_step;
        int          x_len;
        logic [31:0] y0;
        logic [31:0] y_base;
        logic [31:0] y_step;
    } vec_t;

    vec_t        vecs [5];
    vec_t        cur;
    logic [31:0] y_mem [VS];
    int          wr_count = 0;
    int          bad_wr   = 0;
    logic        clr_y    = 1'b0;
    logic [31:0] rd_p1    = '0;
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic vec_t mk(input string n, input logic [31:0] md, input int dl,
                                input logic [31:0] mo, input logic [31:0] xb,
                                input logic [31:0] xs, input int xl,
                                input logic [31:0] y0, input logic [31:0] yb,
                                input logic [31:0] ys);
        vec_t v;
        v.name = n; v.m_diag = md; v.diag_len = dl; v.m_off = mo;
        v.x_base = xb; v.x_step = xs; v.x_len = xl;
        v.y0 = y0; v.y_base = yb; v.y_step = ys;
        return v;
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        int i;
        int j;
        if (a < 32'(MAT_W)) begin
            i = int'(a) / VS;
            j = int'(a) % VS;
            if (i != j) return cur.m_off;
            return (i < cur.diag_len) ? cur.m_diag : 32'h0;
        end else if (a < 32'(RES_BASE)) begin
            j = int'(a) - MAT_W;
            return (j < cur.x_len) ? cur.x_base + 32'(j) * cur.x_step : 32'h0;
        end
        return 32'h0;
    endfunction

    // Behavioural BRAM: address registered on one edge, data out on the next.
    always @(posedge BRAM_CLK) begin
        if (clr_y) begin
            for (int i = 0; i < VS; i++) y_mem[i] = 32'hDEADBEEF;
            wr_count = 0;
            bad_wr   = 0;
        end else if (BRAM_WE != 4'h0) begin
            wr_count++;
            if (BRAM_WE == 4'hF && BRAM_ADDR[1:0] == 2'b00 &&
                BRAM_ADDR >= 32'(RES_BASE * 4) && BRAM_ADDR < 32'((RES_BASE + VS) * 4))
                y_mem[int'(BRAM_ADDR >> 2) - RES_BASE] = BRAM_WRDATA;
            else
                bad_wr++;
        end
        rd_p1       <= word_at(BRAM_ADDR >> 2);
        BRAM_RDDATA <= rd_p1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_results();
        @(negedge aclk);
        clr_y = 1'b1;
        @(negedge aclk);
        clr_y = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge aclk);
        start = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        start = 1'b0;
    endtask

    // ign_at >= 0 re-pulses start that many cycles into LOAD; it must be
    // ignored, so the read address keeps counting from the original start.
    task automatic run_job(input int ign_at);
        int cycles;
        pulse_start();
        check("done_low_after_start", 32'(done), 32'd0);
        cycles = 0;
        while (done !== 1'b1 && cycles < BUDGET) begin
            start = (cycles == ign_at);
            @(posedge aclk);
            @(negedge aclk);
            cycles++;
            if (ign_at >= 0 && cycles == ign_at + 5)
                check("load_addr_after_ignored_start", BRAM_ADDR, 32'((ign_at + 5) * 4));
        end
        start = 1'b0;
        check("done_within_budget", 32'(done), 32'd1);
    endtask

    task automatic check_results(input vec_t v);
        logic [31:0] exp;
        for (int i = 0; i < VS; i++) begin
            exp = (i == 0) ? v.y0 : v.y_base + 32'(i) * v.y_step;
            check($sformatf("%s y[%0d]", v.name, i), y_mem[i], exp);
        end
        check($sformatf("%s write_count", v.name), 32'(wr_count), 32'(VS));
        check($sformatf("%s stray_writes", v.name), 32'(bad_wr), 32'd0);
        repeat (3) @(negedge aclk);
        check($sformatf("%s done_held", v.name), 32'(done), 32'd1);
        check($sformatf("%s we_idle_in_done", v.name), 32'(BRAM_WE), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        //            name          m_diag        dl  m_off         x_base        x_step        xl  y0            y_base        y_step
        vecs[0] = mk("identity",   32'h00010000, 64, 32'h00000000, 32'h00000000, 32'h00010000, 64, 32'h00000000, 32'h00000000, 32'h00010000);
        vecs[1] = mk("all_ones",   32'h00010000, 64, 32'h00010000, 32'h00020000, 32'h00000000, 64, 32'h00800000, 32'h00800000, 32'h00000000);
        vecs[2] = mk("neg_single", 32'hFFFF0000,  1, 32'h00000000, 32'h00030000, 32'h00000000,  1, 32'hFFFD0000, 32'h00000000, 32'h00000000);
        vecs[3] = mk("trunc_wrap", 32'h7FFF0000, 64, 32'h00000000, 32'h00040000, 32'h00000000, 64, 32'hFFFC0000, 32'hFFFC0000, 32'h00000000);
        vecs[4] = mk("neg_accum",  32'hFFFF8000, 64, 32'hFFFF8000, 32'h00010000, 32'h00000000, 64, 32'hFFE00000, 32'hFFE00000, 32'h00000000);
        cur = vecs[0];

        // Reset held for 100 cycles, then idle with no start.
        bad = 0;
        repeat (100) begin
            @(negedge aclk);
            if (done !== 1'b0 || BRAM_WE !== 4'h0 || BRAM_ADDR !== 32'h0 || BRAM_WRDATA !== '0) bad++;
        end
        check("reset_outputs_quiet", 32'(bad), 32'd0);
        aresetn = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge aclk);
            if (done !== 1'b0 || BRAM_WE !== 4'h0 || BRAM_ADDR !== 32'h0) bad++;
        end
        check("idle_no_start_quiet", 32'(bad), 32'd0);
        check("idle_no_writes", 32'(wr_count), 32'd0);

        // Table-driven jobs.
        for (int v = 0; v < 5; v++) begin
            cur = vecs[v];
            clear_results();
            run_job(-1);
            check_results(vecs[v]);
        end

        // Restart from DONE, with a start pulse during LOAD that must be ignored.
        clear_results();
        run_job(100);
        check_results(vecs[4]);

        // Reset in the middle of CALC for row 0, before any result write.
        cur = vecs[0];
        clear_results();
        pulse_start();
        repeat (4180) @(negedge aclk);
        aresetn = 1'b0;
        #1;
        check("midcalc_reset_done", 32'(done), 32'd0);
        check("midcalc_reset_we", 32'(BRAM_WE), 32'd0);
        check("midcalc_reset_addr", BRAM_ADDR, 32'd0);
        check("midcalc_reset_wrdata", BRAM_WRDATA, 32'd0);
        repeat (5) @(negedge aclk);
        aresetn = 1'b1;
        repeat (300) @(negedge aclk);
        check("abandoned_job_no_writes", 32'(wr_count), 32'd0);
        check("abandoned_job_idle_done", 32'(done), 32'd0);
        check("abandoned_job_idle_addr", BRAM_ADDR, 32'd0);
        run_job(-1);
        check_results(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
